// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter: count direction and boundary mode.
package counter_pkg;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;
endpackage

// File: rtl/tick_prescaler.sv
// Enable divider: tick fires on the PRESCALE-th enabled cycle, then the count restarts.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  // With PRESCALE=1 LAST is 0, so cnt stays 0 and tick simply follows en.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || restart) cnt <= '0;
    else if (en)          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-(MAX_VAL+1) counter with prescaled stepping, load, clear,
// wrap pulse and a sticky boundary flag.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 9,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  generate
    if (MAX_VAL < 1 || (WIDTH < 31 && MAX_VAL > (1 << WIDTH) - 1)) begin : g_bad_max
      $error("updown_mod_counter: MAX_VAL out of range 1..2**WIDTH-1");
    end
    if (PRESCALE < 1) begin : g_bad_pre
      $error("updown_mod_counter: PRESCALE must be at least 1");
    end
  endgenerate

  logic             step;
  logic             at_top, at_bot, boundary;
  logic [WIDTH-1:0] step_val;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (clear | load),
    .tick    (step)
  );

  assign at_top   = (count == MAXV);
  assign at_bot   = (count == '0);
  assign tc       = en && ((up_dn == DIR_UP) ? at_top : at_bot);
  assign boundary = step && ((up_dn == DIR_UP) ? at_top : at_bot);

  always_comb begin
    step_val = count;
    if (up_dn == DIR_UP) begin
      if (!at_top)                 step_val = count + 1'b1;
      else if (SATURATE == MODE_WRAP) step_val = '0;
    end else begin
      if (!at_bot)                 step_val = count - 1'b1;
      else if (SATURATE == MODE_WRAP) step_val = MAXV;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      // Out-of-range loads clamp so count never leaves 0..MAX_VAL.
      count <= (load_val > MAXV) ? MAXV : load_val;
      wrap  <= 1'b0;
    end else begin
      wrap <= boundary && (SATURATE == MODE_WRAP);
      if (step)     count <= step_val;
      if (boundary) ovf   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: default, saturating and PRESCALE=3 instances.
module tb_updown_mod_counter;
  typedef struct packed {
    logic       reset, en, up_dn, clear, load;
    logic [3:0] load_val;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [3:0] count;
    logic       wrap, ovf, tc;
  } vec_t;

  logic clk = 1'b0;
  in_t  in0, in1, in2;
  logic [3:0] count0, count1, count2;
  logic tc0, tc1, tc2, wrap0, wrap1, wrap2, ovf0, ovf1, ovf2;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(0)) dut0 (
    .clk(clk), .reset(in0.reset), .en(in0.en), .up_dn(in0.up_dn), .clear(in0.clear),
    .load(in0.load), .load_val(in0.load_val), .count(count0), .tc(tc0), .wrap(wrap0), .ovf(ovf0));
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1)) dut1 (
    .clk(clk), .reset(in1.reset), .en(in1.en), .up_dn(in1.up_dn), .clear(in1.clear),
    .load(in1.load), .load_val(in1.load_val), .count(count1), .tc(tc1), .wrap(wrap1), .ovf(ovf1));
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3), .SATURATE(0)) dut2 (
    .clk(clk), .reset(in2.reset), .en(in2.en), .up_dn(in2.up_dn), .clear(in2.clear),
    .load(in2.load), .load_val(in2.load_val), .count(count2), .tc(tc2), .wrap(wrap2), .ovf(ovf2));

  function automatic vec_t mk(string name, logic r, logic e, logic u, logic c, logic l,
                              logic [3:0] lv, logic [3:0] cnt, logic w, logic o, logic t);
    vec_t v;
    v.name = name;
    v.in = '{reset: r, en: e, up_dn: u, clear: c, load: l, load_val: lv};
    v.count = cnt; v.wrap = w; v.ovf = o; v.tc = t;
    return v;
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector on the chosen instance, queue its expectation, and check after the edge.
  task automatic apply(int d, vec_t v);
    vec_t e;
    @(negedge clk);
    in0 = '0; in1 = '0; in2 = '0;
    case (d)
      0: in0 = v.in;
      1: in1 = v.in;
      default: in2 = v.in;
    endcase
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    case (d)
      0: begin
        chk({e.name, ".count"}, count0, e.count); chk({e.name, ".wrap"}, {3'b0, wrap0}, {3'b0, e.wrap});
        chk({e.name, ".ovf"}, {3'b0, ovf0}, {3'b0, e.ovf}); chk({e.name, ".tc"}, {3'b0, tc0}, {3'b0, e.tc});
      end
      1: begin
        chk({e.name, ".count"}, count1, e.count); chk({e.name, ".wrap"}, {3'b0, wrap1}, {3'b0, e.wrap});
        chk({e.name, ".ovf"}, {3'b0, ovf1}, {3'b0, e.ovf}); chk({e.name, ".tc"}, {3'b0, tc1}, {3'b0, e.tc});
      end
      default: begin
        chk({e.name, ".count"}, count2, e.count); chk({e.name, ".wrap"}, {3'b0, wrap2}, {3'b0, e.wrap});
        chk({e.name, ".ovf"}, {3'b0, ovf2}, {3'b0, e.ovf}); chk({e.name, ".tc"}, {3'b0, tc2}, {3'b0, e.tc});
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    in0 = '0; in1 = '0; in2 = '0;

    // Default instance: name, reset, en, up_dn, clear, load, load_val -> count, wrap, ovf, tc
    tbl.push_back(mk("rst",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] c;
      c = 4'(k % 10);
      tbl.push_back(mk($sformatf("up%0d", k), 0, 1, 1, 0, 0, 0, c, k == 10, k >= 10, c == 4'd9));
    end
    tbl.push_back(mk("clr_dn",   0, 1, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("dn_wrap",  0, 1, 0, 0, 0, 0, 9, 1, 1, 0));
    tbl.push_back(mk("dn8",      0, 1, 0, 0, 0, 0, 8, 0, 1, 0));
    tbl.push_back(mk("ld15_en",  0, 1, 1, 0, 1, 15, 9, 0, 1, 1));
    tbl.push_back(mk("ld3_en",   0, 1, 1, 0, 1, 3, 3, 0, 1, 0));
    tbl.push_back(mk("hold_en0", 0, 0, 1, 0, 0, 0, 3, 0, 1, 0));
    tbl.push_back(mk("dir_chg",  0, 0, 0, 0, 0, 0, 3, 0, 1, 0));
    tbl.push_back(mk("dn_after", 0, 1, 0, 0, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk("ld6",      0, 0, 0, 0, 1, 6, 6, 0, 1, 0));
    tbl.push_back(mk("rst_ld",   1, 0, 0, 0, 1, 5, 0, 0, 0, 0));
    tbl.push_back(mk("dn_wrap2", 0, 1, 0, 0, 0, 0, 9, 1, 1, 0));
    tbl.push_back(mk("clr_ovf",  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("clr_step", 0, 1, 0, 1, 0, 0, 0, 0, 0, 1));
    foreach (tbl[i]) apply(0, tbl[i]);

    // Saturating instance: hold at both boundaries, never pulse wrap.
    apply(1, mk("s_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(1, mk("s_dn0",    0, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    apply(1, mk("s_dn0b",   0, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    apply(1, mk("s_ld8",    0, 0, 1, 0, 1, 8, 8, 0, 1, 0));
    apply(1, mk("s_clr",    0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    apply(1, mk("s_ld8b",   0, 0, 1, 0, 1, 8, 8, 0, 0, 0));
    apply(1, mk("s_up9",    0, 1, 1, 0, 0, 0, 9, 0, 0, 1));
    apply(1, mk("s_up_hld", 0, 1, 1, 0, 0, 0, 9, 0, 1, 1));

    // PRESCALE=3: one step per three enabled cycles.
    apply(2, mk("p_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 9; k++)
      apply(2, mk($sformatf("p_run%0d", k), 0, 1, 1, 0, 0, 0, 4'(k / 3), 0, 0, 0));
    apply(2, mk("p_st1",   0, 1, 1, 0, 0, 0, 3, 0, 0, 0));
    apply(2, mk("p_off1",  0, 0, 1, 0, 0, 0, 3, 0, 0, 0));
    apply(2, mk("p_off2",  0, 0, 1, 0, 0, 0, 3, 0, 0, 0));
    apply(2, mk("p_st2",   0, 1, 1, 0, 0, 0, 3, 0, 0, 0));
    apply(2, mk("p_st3",   0, 1, 1, 0, 0, 0, 4, 0, 0, 0));
    // Load restarts the prescaler.
    apply(2, mk("p_pre1",  0, 1, 1, 0, 0, 0, 4, 0, 0, 0));
    apply(2, mk("p_ld0",   0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    apply(2, mk("p_ldA",   0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(2, mk("p_ldB",   0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(2, mk("p_ldC",   0, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    // Reset mid-prescale, then a full three cycles to the first step.
    apply(2, mk("p_pre2",  0, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    apply(2, mk("p_rst2",  1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(2, mk("p_r1",    0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(2, mk("p_r2",    0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(2, mk("p_r3",    0, 1, 1, 0, 0, 0, 1, 0, 0, 0));

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
